// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - packet-reception controller for the 1x3 router
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] addr;
  logic       hdr_ok;
  logic       empty_hdr;
  logic       empty_addr;
  logic       soft_hit;

  // Header accepted only for a real port; address 3 is ignored.
  assign hdr_ok = pkt_valid && (data_in != 2'd3);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == DECODE_ADDRESS && hdr_ok)
        addr <= data_in;
    end
  end

  always_comb begin
    empty_hdr  = 1'b0;
    empty_addr = 1'b0;
    soft_hit   = 1'b0;
    case (data_in)
      2'd0:    empty_hdr = fifo_empty_0;
      2'd1:    empty_hdr = fifo_empty_1;
      2'd2:    empty_hdr = fifo_empty_2;
      default: empty_hdr = 1'b0;
    endcase
    case (addr)
      2'd0:    begin empty_addr = fifo_empty_0; soft_hit = soft_reset_0; end
      2'd1:    begin empty_addr = fifo_empty_1; soft_hit = soft_reset_1; end
      2'd2:    begin empty_addr = fifo_empty_2; soft_hit = soft_reset_2; end
      default: begin empty_addr = 1'b0;         soft_hit = 1'b0;         end
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (state != DECODE_ADDRESS && soft_hit) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (hdr_ok) state_nxt = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (empty_addr) state_nxt = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          state_nxt = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt = LOAD_PARITY;
          else                    state_nxt = LOAD_DATA;
        LOAD_PARITY:
          state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign write_enb_reg = lfd_state || ld_state || laf_state || (state == LOAD_PARITY);
  assign busy          = !(detect_add || ld_state);

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - table-driven and randomized bench for router_fsm
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [2:0] emp, sr;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;
  logic [7:0] out_vec;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(emp[0]), .fifo_empty_1(emp[1]), .fifo_empty_2(emp[2]),
    .soft_reset_0(sr[0]), .soft_reset_1(sr[1]), .soft_reset_2(sr[2]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  assign out_vec = {detect_add, lfd_state, ld_state, laf_state,
                    full_state, write_enb_reg, rst_int_reg, busy};

  // Output bundle {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0101;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  typedef struct {
    int         grp;
    logic       rn, pv;
    logic [1:0] d;
    logic       ff;
    logic [2:0] emp, sr;
    logic       pd, lpv;
    logic [7:0] exp;
  } vec_t;

  vec_t  vecs[$];
  string grp_name[7] = '{"reset", "normal_p2", "busy_dest", "full_stall",
                         "soft_reset", "invalid_addr", "parity_paths"};

  task automatic add(input int g, input logic rn, input logic pv, input logic [1:0] d,
                     input logic ff, input logic [2:0] e, input logic [2:0] s,
                     input logic pd, input logic lpv, input logic [7:0] x);
    vec_t v;
    v.grp = g; v.rn = rn; v.pv = pv; v.d = d; v.ff = ff;
    v.emp = e; v.sr = s; v.pd = pd; v.lpv = lpv; v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rn, input logic pv, input logic [1:0] d, input logic ff,
                       input logic [2:0] e, input logic [2:0] s, input logic pd,
                       input logic lpv);
    resetn = rn; pkt_valid = pv; data_in = d; fifo_full = ff;
    emp = e; sr = s; parity_done = pd; low_pkt_valid = lpv;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] exp);
    checks++;
    if (out_vec !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, out_vec, exp);
    end
  endtask

  // Reference model: packet phases named by their role, not by the DUT encoding.
  localparam int P_IDLE = 0, P_FIRST = 1, P_BODY = 2, P_STALL = 3, P_RESUME = 4,
                 P_PAR = 5, P_CHECK = 6, P_WAIT = 7;
  int         m_phase;
  logic [1:0] m_port;

  function automatic logic [7:0] phase_out(input int p);
    case (p)
      P_IDLE:   return O_DA;
      P_FIRST:  return O_LFD;
      P_BODY:   return O_LD;
      P_STALL:  return O_FFS;
      P_RESUME: return O_LAF;
      P_PAR:    return O_LP;
      P_CHECK:  return O_CPE;
      default:  return O_WTE;
    endcase
  endfunction

  task automatic model_step();
    int nxt;
    nxt = m_phase;
    if (!resetn) begin
      m_phase = P_IDLE;
      m_port  = 2'd0;
      return;
    end
    if (m_phase != P_IDLE && m_port != 2'd3 && sr[m_port]) nxt = P_IDLE;
    else if (m_phase == P_IDLE) begin
      if (pkt_valid && data_in != 2'd3) begin
        nxt    = emp[data_in] ? P_FIRST : P_WAIT;
        m_port = data_in;
      end
    end
    else if (m_phase == P_WAIT)   nxt = emp[m_port] ? P_FIRST : P_WAIT;
    else if (m_phase == P_FIRST)  nxt = P_BODY;
    else if (m_phase == P_BODY)   nxt = fifo_full ? P_STALL : (!pkt_valid ? P_PAR : P_BODY);
    else if (m_phase == P_STALL)  nxt = fifo_full ? P_STALL : P_RESUME;
    else if (m_phase == P_RESUME) nxt = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
    else if (m_phase == P_PAR)    nxt = P_CHECK;
    else                          nxt = fifo_full ? P_STALL : P_IDLE;
    m_phase = nxt;
  endtask

  initial begin
    drive(0, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0);

    // reset held with pkt_valid high, then idle after release
    add(0, 0, 1, 2'd2, 0, 3'b111, 0, 0, 0, O_DA);
    add(0, 0, 1, 2'd2, 0, 3'b111, 0, 0, 0, O_DA);
    add(0, 1, 0, 2'd2, 0, 3'b111, 0, 0, 0, O_DA);
    add(0, 1, 0, 2'd0, 0, 3'b111, 0, 0, 0, O_DA);
    // port 2 packet, three LD cycles
    add(1, 1, 1, 2'd2, 0, 3'b100, 0, 0, 0, O_LFD);
    add(1, 1, 1, 2'd2, 0, 3'b100, 0, 0, 0, O_LD);
    add(1, 1, 1, 2'd2, 0, 3'b100, 0, 0, 0, O_LD);
    add(1, 1, 1, 2'd2, 0, 3'b100, 0, 0, 0, O_LD);
    add(1, 1, 0, 2'd2, 0, 3'b100, 0, 0, 0, O_LP);
    add(1, 1, 0, 2'd2, 0, 3'b100, 0, 0, 0, O_CPE);
    add(1, 1, 0, 2'd2, 0, 3'b100, 0, 0, 0, O_DA);
    // port 1 busy for 4 cycles, then drains
    add(2, 1, 1, 2'd1, 0, 3'b101, 0, 0, 0, O_WTE);
    add(2, 1, 1, 2'd1, 0, 3'b101, 0, 0, 0, O_WTE);
    add(2, 1, 1, 2'd1, 0, 3'b101, 0, 0, 0, O_WTE);
    add(2, 1, 1, 2'd1, 0, 3'b101, 0, 0, 0, O_WTE);
    add(2, 1, 1, 2'd1, 0, 3'b111, 0, 0, 0, O_LFD);
    add(2, 1, 1, 2'd1, 0, 3'b111, 0, 0, 0, O_LD);
    // full stall back to LD, then a second stall ending in LP
    add(3, 1, 1, 2'd1, 1, 3'b111, 0, 0, 0, O_FFS);
    add(3, 1, 1, 2'd1, 1, 3'b111, 0, 0, 0, O_FFS);
    add(3, 1, 1, 2'd1, 1, 3'b111, 0, 0, 0, O_FFS);
    add(3, 1, 1, 2'd1, 0, 3'b111, 0, 0, 0, O_LAF);
    add(3, 1, 1, 2'd1, 0, 3'b111, 0, 0, 0, O_LD);
    add(3, 1, 0, 2'd1, 1, 3'b111, 0, 0, 0, O_FFS);
    add(3, 1, 0, 2'd1, 0, 3'b111, 0, 0, 0, O_LAF);
    add(3, 1, 0, 2'd1, 0, 3'b111, 0, 0, 1, O_LP);
    add(3, 1, 0, 2'd1, 0, 3'b111, 0, 0, 0, O_CPE);
    add(3, 1, 0, 2'd1, 0, 3'b111, 0, 0, 0, O_DA);
    // soft reset: wrong port ignored, matching port aborts
    add(4, 1, 1, 2'd0, 0, 3'b111, 0, 0, 0, O_LFD);
    add(4, 1, 1, 2'd0, 0, 3'b111, 0, 0, 0, O_LD);
    add(4, 1, 1, 2'd0, 0, 3'b111, 3'b010, 0, 0, O_LD);
    add(4, 1, 1, 2'd0, 1, 3'b111, 3'b001, 0, 0, O_DA);
    add(4, 1, 1, 2'd2, 0, 3'b011, 0, 0, 0, O_WTE);
    add(4, 1, 1, 2'd2, 0, 3'b011, 3'b100, 0, 0, O_DA);
    // invalid address never leaves DA
    add(5, 1, 1, 2'd3, 0, 3'b111, 0, 0, 0, O_DA);
    add(5, 1, 1, 2'd3, 0, 3'b111, 0, 0, 0, O_DA);
    add(5, 1, 1, 2'd3, 0, 3'b111, 0, 0, 0, O_DA);
    // CPE into FFS on full, then parity_done ends the packet from LAF
    add(6, 1, 1, 2'd0, 0, 3'b111, 0, 0, 0, O_LFD);
    add(6, 1, 0, 2'd0, 0, 3'b111, 0, 0, 0, O_LD);
    add(6, 1, 0, 2'd0, 0, 3'b111, 0, 0, 0, O_LP);
    add(6, 1, 0, 2'd0, 0, 3'b111, 0, 0, 0, O_CPE);
    add(6, 1, 0, 2'd0, 1, 3'b111, 0, 0, 0, O_FFS);
    add(6, 1, 0, 2'd0, 0, 3'b111, 0, 0, 0, O_LAF);
    add(6, 1, 0, 2'd0, 0, 3'b111, 0, 1, 1, O_DA);

    @(negedge clock);
    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].pv, vecs[i].d, vecs[i].ff, vecs[i].emp,
            vecs[i].sr, vecs[i].pd, vecs[i].lpv);
      @(posedge clock);
      #1;
      check(grp_name[vecs[i].grp], i, vecs[i].exp);
    end

    drive(0, 0, 2'd0, 0, 3'b111, 0, 0, 0);
    @(posedge clock);
    model_step();
    #1;
    check("rand_reset", 0, phase_out(m_phase));

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      @(posedge clock);
      model_step();
      #1;
      check("random", i, phase_out(m_phase));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
